// File: rtl/bramcache_ctrl.sv
// bramcache_ctrl: direct-mapped write-back cache controller in front of the dual-port bramcache store
// Ports: clock/reset (sync, active-high); cpu_req/cpu_we/cpu_be/cpu_addr -> cpu_ready, bram_a_wren
// qualify CPU accesses on BRAM port A; bram_b_addr/bram_b_wren/bram_b_data/bram_b_q move lines on
// port B; mem_req/mem_we/mem_addr/mem_rvalid/mem_rdata/mem_wvalid/mem_wnext/mem_wdata form the
// external burst interface; flush_req/flush_busy control the whole-cache flush.
// Optional feature: define BRAMCACHE_FLUSH_EN to build the flush walk (FLUSH_SCAN state).
module bramcache_ctrl #(
  parameter int ADDR_W = 20,
  parameter int IDX_W = 3,
  parameter int OFF_W = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [3:0]              cpu_be,
  input  logic [ADDR_W-1:0]       cpu_addr,
  output logic                    cpu_ready,
  output logic [3:0]              bram_a_wren,
  output logic [IDX_W+OFF_W-1:0]  bram_b_addr,
  output logic [3:0]              bram_b_wren,
  output logic [31:0]             bram_b_data,
  input  logic [31:0]             bram_b_q,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_W-OFF_W-1:0] mem_addr,
  input  logic                    mem_rvalid,
  input  logic [31:0]             mem_rdata,
  output logic                    mem_wvalid,
  input  logic                    mem_wnext,
  output logic [31:0]             mem_wdata,
  input  logic                    flush_req,
  output logic                    flush_busy
);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int LINES = 2 ** IDX_W;
`ifdef BRAMCACHE_FLUSH_EN
  typedef enum logic [2:0] {IDLE, WB_RD, WB, FILL, FLUSH_SCAN} state_t;
`else
  typedef enum logic [1:0] {IDLE, WB_RD, WB, FILL} state_t;
`endif
  state_t state;
  logic [LINES-1:0] valid, dirty;
  logic [TAG_W-1:0] tags [LINES];
  logic [IDX_W-1:0] line;
  logic [OFF_W-1:0] off;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic hit, miss, fill_word, unused_bits;
  assign idx = cpu_addr[IDX_W+OFF_W-1:OFF_W];
  assign tag = cpu_addr[ADDR_W-1:IDX_W+OFF_W];
  assign hit = cpu_req && state == IDLE && valid[idx] && tags[idx] == tag;
  assign miss = cpu_req && state == IDLE && !hit;
  // mem_req is low for the first FILL cycle after a writeback; words are only taken once it is high
  assign fill_word = state == FILL && mem_req && mem_rvalid;
  assign cpu_ready = hit;
  assign bram_a_wren = (hit && cpu_we) ? cpu_be : 4'h0;
  assign bram_b_addr = {line, off};
  assign bram_b_wren = fill_word ? 4'hF : 4'h0;
  assign bram_b_data = mem_rdata;
  assign mem_wdata = bram_b_q;
`ifdef BRAMCACHE_FLUSH_EN
  logic flushing;
  assign unused_bits = ^cpu_addr[OFF_W-1:0];
`else
  assign flush_busy = 1'b0;
  assign unused_bits = ^{cpu_addr[OFF_W-1:0], flush_req};
`endif
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      valid <= '0;
      dirty <= '0;
      line <= '0;
      off <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wvalid <= 1'b0;
`ifdef BRAMCACHE_FLUSH_EN
      flush_busy <= 1'b0;
      flushing <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (hit && cpu_we) dirty[idx] <= 1'b1;
          if (miss) begin
            line <= idx;
            off <= '0;
            mem_req <= 1'b1;
            mem_we <= dirty[idx];
            mem_addr <= dirty[idx] ? {tags[idx], idx} : {tag, idx};
            state <= dirty[idx] ? WB_RD : FILL;
          end
`ifdef BRAMCACHE_FLUSH_EN
          // a flush that arrives with a miss stays pending in flush_busy until the miss is done
          if (flush_req) flush_busy <= 1'b1;
          if (!miss && (flush_req || flush_busy)) begin
            line <= '0;
            flushing <= 1'b1;
            state <= FLUSH_SCAN;
          end
`endif
        end
        WB_RD: begin
          mem_wvalid <= 1'b1;
          state <= WB;
        end
        WB: if (mem_wnext) begin
          mem_wvalid <= 1'b0;
          off <= off + 1'b1;
          if (&off) begin
            mem_req <= 1'b0;
            mem_we <= 1'b0;
`ifdef BRAMCACHE_FLUSH_EN
            if (flushing) begin
              dirty[line] <= 1'b0;
              state <= FLUSH_SCAN;
            end else
`endif
            begin
              mem_addr <= {tag, line};
              state <= FILL;
            end
          end else state <= WB_RD;
        end
        FILL: begin
          mem_req <= 1'b1;
          if (fill_word) begin
            off <= off + 1'b1;
            if (&off) begin
              valid[line] <= 1'b1;
              dirty[line] <= 1'b0;
              tags[line] <= tag;
              mem_req <= 1'b0;
              state <= IDLE;
            end
          end
        end
`ifdef BRAMCACHE_FLUSH_EN
        FLUSH_SCAN: if (dirty[line]) begin
          off <= '0;
          mem_req <= 1'b1;
          mem_we <= 1'b1;
          mem_addr <= {tags[line], line};
          state <= WB_RD;
        end else if (&line) begin
          valid <= '0;
          flush_busy <= 1'b0;
          flushing <= 1'b0;
          state <= IDLE;
        end else line <= line + 1'b1;
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bramcache_ctrl.sv
// tb_bramcache_ctrl: scoreboard bench for bramcache_ctrl with BRAM and burst-memory models
module tb_bramcache_ctrl;
  logic clock = 0, reset = 1;
  logic cpu_req = 0, cpu_we = 0;
  logic [3:0] cpu_be = 0;
  logic [19:0] cpu_addr = 0;
  logic [31:0] cpu_wdata = 0;
  logic cpu_ready, mem_req, mem_we, mem_wvalid, flush_busy;
  logic [3:0] bram_a_wren, bram_b_wren;
  logic [5:0] bram_b_addr;
  logic [31:0] bram_b_data, bram_b_q, mem_wdata, q_a;
  logic [16:0] mem_addr;
  logic mem_rvalid = 0, mem_wnext = 0, flush_req = 0;
  logic [31:0] mem_rdata = 0;
  logic [31:0] bram [64];
  logic [31:0] shadow [64];
  logic [31:0] mem_store [logic [19:0]];
  logic [31:0] wb_q[$], rd_q[$];
  logic [17:0] burst_q[$];
  logic [2:0] fill_idx = 0;
  int n_chk = 0, n_pass = 0, fill_words = 0, bursts = 0, stall_at = -1, stall_len = 0;
  int r_off = 0, r_wb = 0, r_stall_left = 0, b0 = 0, fw0 = 0;
  logic r_stalling = 0, prev_req = 0;
  logic [31:0] r_stall_word = 0, r_e = 0;

  bramcache_ctrl dut (
    .clock(clock), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be),
    .cpu_addr(cpu_addr), .cpu_ready(cpu_ready), .bram_a_wren(bram_a_wren),
    .bram_b_addr(bram_b_addr), .bram_b_wren(bram_b_wren), .bram_b_data(bram_b_data),
    .bram_b_q(bram_b_q), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_wvalid(mem_wvalid),
    .mem_wnext(mem_wnext), .mem_wdata(mem_wdata), .flush_req(flush_req), .flush_busy(flush_busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    for (int b = 0; b < 4; b++) begin
      if (bram_a_wren[b]) bram[cpu_addr[5:0]][8*b +: 8] <= cpu_wdata[8*b +: 8];
      if (bram_b_wren[b]) bram[bram_b_addr][8*b +: 8] <= bram_b_data[8*b +: 8];
    end
    q_a <= bram[cpu_addr[5:0]];
    bram_b_q <= bram[bram_b_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] memword(input logic [16:0] la, input logic [2:0] o);
    logic [19:0] k;
    k = {la, o};
    return mem_store.exists(k) ? mem_store[k] : {8'hC5, la, 4'h0, o};
  endfunction

  task automatic fill_model(input logic [19:0] a);
    burst_q.push_back({1'b0, a[19:3]});
    for (int o = 0; o < 8; o++) shadow[{a[5:3], 3'(o)}] = memword(a[19:3], 3'(o));
  endtask

  task automatic wb_model(input logic [2:0] i, input logic [16:0] la);
    burst_q.push_back({1'b1, la});
    for (int o = 0; o < 8; o++) wb_q.push_back(shadow[{i, 3'(o)}]);
  endtask

  task automatic access(input logic [19:0] a, input logic we, input logic [3:0] be,
                        input logic [31:0] wd, input int exp_cyc);
    int cyc = 0;
    cpu_addr = a; cpu_we = we; cpu_be = be; cpu_wdata = wd; cpu_req = 1; fill_idx = a[5:3];
    #1;
    while (!cpu_ready && cyc < 200) begin
      @(negedge clock); #1; cyc++;
    end
    chk($sformatf("cycles_%05h", a), cyc, exp_cyc);
    chk($sformatf("a_wren_%05h", a), {28'h0, bram_a_wren}, {28'h0, we ? be : 4'h0});
    @(negedge clock);
    cpu_req = 0; cpu_we = 0; cpu_be = 0;
    if (!we) chk($sformatf("q_a_%05h", a), q_a, rd_q.pop_front());
  endtask

  task automatic rd(input logic [19:0] a, input int cyc);
    rd_q.push_back(shadow[a[5:0]]);
    access(a, 1'b0, 4'h0, 32'h0, cyc);
  endtask

  task automatic wr(input logic [19:0] a, input logic [3:0] be, input logic [31:0] d, input int cyc);
    for (int b = 0; b < 4; b++) if (be[b]) shadow[a[5:0]][8*b +: 8] = d[8*b +: 8];
    access(a, 1'b1, be, d, cyc);
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (mem_req && !prev_req) begin
        bursts++;
        chk("burst_expected", {31'h0, burst_q.size() > 0}, 32'h1);
        if (burst_q.size() > 0) chk("burst", {14'h0, mem_we, mem_addr}, {14'h0, burst_q.pop_front()});
      end
      prev_req = mem_req;
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      mem_rvalid = 0; mem_wnext = 0;
      if (!mem_req) begin
        r_off = 0; r_wb = 0;
      end else if (!mem_we) begin
        if (r_off < 8) begin
          r_e = memword(mem_addr, 3'(r_off));
          mem_rvalid = 1; mem_rdata = r_e; fill_words++;
          #1;
          chk("fill_wren", {28'h0, bram_b_wren}, 32'hF);
          chk("fill_addr", {26'h0, bram_b_addr}, {26'h0, fill_idx, 3'(r_off)});
          chk("fill_data", bram_b_data, r_e);
          r_off++;
        end
      end else if (r_stalling) begin
        chk("stall_wvalid", {31'h0, mem_wvalid}, 32'h1);
        chk("stall_wdata", mem_wdata, r_stall_word);
        r_stall_left--;
        if (r_stall_left == 0) r_stalling = 0;
      end else if (mem_wvalid) begin
        if (r_wb == stall_at && stall_len > 0) begin
          r_stalling = 1; r_stall_left = stall_len - 1; r_stall_word = mem_wdata; stall_len = 0;
        end else begin
          mem_wnext = 1;
          chk("wb_expected", {31'h0, wb_q.size() > 0}, 32'h1);
          if (wb_q.size() > 0) chk($sformatf("wb_data_%0d", r_wb), mem_wdata, wb_q.pop_front());
          mem_store[{mem_addr, 3'(r_wb)}] = mem_wdata;
          r_wb++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    for (int o = 0; o < 8; o++) mem_store[{17'h2, 3'(o)}] = 32'hA0 + o;
    repeat (2) @(negedge clock);
    cpu_req = 1;
    @(negedge clock); #1;
    chk("rst_cpu_ready", {31'h0, cpu_ready}, 0);
    chk("rst_mem_req", {31'h0, mem_req}, 0);
    chk("rst_mem_we", {31'h0, mem_we}, 0);
    chk("rst_mem_wvalid", {31'h0, mem_wvalid}, 0);
    chk("rst_flush_busy", {31'h0, flush_busy}, 0);
    chk("rst_a_wren", {28'h0, bram_a_wren}, 0);
    chk("rst_b_wren", {28'h0, bram_b_wren}, 0);
    chk("rst_mem_addr", {15'h0, mem_addr}, 0);
    chk("rst_b_addr", {26'h0, bram_b_addr}, 0);
    cpu_req = 0; reset = 0;
    @(negedge clock);
    fill_model(20'h00010); rd(20'h00010, 9);
    wr(20'h00011, 4'b0011, 32'hDEADBEEF, 0);
    b0 = bursts; rd(20'h00011, 0); chk("hit_no_burst", bursts, b0);
    wb_model(3'd2, 17'h00002); fill_model(20'h00410);
    stall_at = 3; stall_len = 5;
    rd(20'h00410, 31);
    fill_model(20'h00011); rd(20'h00011, 9);
    burst_q.push_back({1'b0, 17'h00006});
    cpu_addr = 20'h00030; cpu_we = 0; cpu_req = 1; fill_idx = 3'd6; fw0 = fill_words;
    for (int i = 0; i < 100 && fill_words - fw0 < 4; i++) begin
      @(negedge clock); #2;
    end
    chk("rst_fill_progress", fill_words - fw0, 4);
    reset = 1; cpu_req = 0;
    @(negedge clock); #2;
    chk("rst_mid_mem_req", {31'h0, mem_req}, 0);
    chk("rst_mid_cpu_ready", {31'h0, cpu_ready}, 0);
    reset = 0;
    @(negedge clock);
    fill_model(20'h00030); rd(20'h00030, 9);
    fill_model(20'h00011); rd(20'h00011, 9);
    fill_model(20'h00023); wr(20'h00023, 4'b1100, 32'h12345678, 9);
    rd(20'h00023, 0);
    wr(20'h00027, 4'hF, 32'hCAFEF00D, 0);
    wb_model(3'd4, 17'h00004); fill_model(20'h00423); rd(20'h00423, 26);
`ifdef BRAMCACHE_FLUSH_EN
    fill_model(20'h00008); wr(20'h00008, 4'hF, 32'h11111111, 9);
    wr(20'h00031, 4'hF, 32'h66666666, 0);
    wb_model(3'd1, 17'h00001); wb_model(3'd6, 17'h00006);
    b0 = bursts;
    flush_req = 1;
    @(negedge clock);
    flush_req = 0; #1;
    chk("flush_busy_start", {31'h0, flush_busy}, 1);
    for (int i = 0; i < 400 && flush_busy; i++) @(negedge clock);
    #1;
    chk("flush_busy_end", {31'h0, flush_busy}, 0);
    chk("flush_bursts", bursts - b0, 2);
    @(negedge clock);
    fill_model(20'h00008); rd(20'h00008, 9);
    fill_model(20'h00423); rd(20'h00423, 9);
`else
    b0 = bursts;
    flush_req = 1;
    @(negedge clock);
    flush_req = 0; #1;
    chk("flush_ignored_busy", {31'h0, flush_busy}, 0);
    @(negedge clock);
    rd(20'h00423, 0);
    chk("flush_ignored_bursts", bursts, b0);
`endif
    repeat (2) @(negedge clock);
    chk("burst_q_empty", burst_q.size(), 0);
    chk("wb_q_empty", wb_q.size(), 0);
    chk("rd_q_empty", rd_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/bramcache_ctrl.md
# bramcache_ctrl

Direct-mapped, write-back cache controller that sits directly upstream of the dual-port `bramcache` data store. It owns the tag/valid/dirty state, qualifies CPU accesses on BRAM port A, and drives BRAM port B to fill lines from, and write dirty lines back to, the external memory burst interface. Data is 32 bits wide with 4 byte lanes, matching the `bramcache` `wren[3:0]` lanes.

## Interface
Parameters:
- `ADDR_W`, 20: CPU word-address width.
- `IDX_W`, 3: line-index bits, giving 2**IDX_W lines.
- `OFF_W`, 3: word-in-line bits, giving LINE_WORDS = 2**OFF_W.

Ports:
- `clock`  in  1  single clock; every register is on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `cpu_req`  in  1  access request. `cpu_addr`, `cpu_we` and `cpu_be` must be held stable until `cpu_ready` is high.
- `cpu_we`  in  1  write (1) or read (0).
- `cpu_be`  in  4  byte enables for a write.
- `cpu_addr`  in  ADDR_W  word address. The CPU drives BRAM port A address `cpu_addr[IDX_W+OFF_W-1:0]` directly.
- `cpu_ready`  out  1  hit; the access completes this cycle.
- `bram_a_wren`  out  4  equals `cpu_be` when `cpu_req & cpu_we & cpu_ready`, else 0.
- `bram_b_addr`  out  IDX_W+OFF_W  port B address as {index, offset}.
- `bram_b_wren`  out  4  4'hF during a fill word, else 0.
- `bram_b_data`  out  32  fill data, equal to `mem_rdata`.
- `bram_b_q`  in  32  port B read data. Valid 1 cycle after the address is presented.
- `mem_req`  out  1  burst request, held for the whole burst.
- `mem_we`  out  1  1 = writeback burst, 0 = fill burst.
- `mem_addr`  out  ADDR_W-OFF_W  line address.
- `mem_rvalid`  in  1  fill word strobe.
- `mem_rdata`  in  32  fill word.
- `mem_wvalid`  out  1  writeback word valid.
- `mem_wnext`  in  1  writeback word accepted.
- `mem_wdata`  out  32  writeback word, equal to `bram_b_q`.
- `flush_req`  in  1  start a flush; see Configuration.
- `flush_busy`  out  1  a flush is in progress.

## Operation
- Tag array is registers: per line one valid bit, one dirty bit, and a tag of `cpu_addr[ADDR_W-1:IDX_W+OFF_W]`.
- Hit = `cpu_req` & state IDLE & valid[idx] & tag match.
- A write hit sets dirty[idx].
- States:
  - IDLE: on a miss, go to WB_RD if dirty[idx], else go to FILL.
  - WB_RD: present `bram_b_addr` = {idx, off}, then go to WB.
  - WB: assert `mem_wvalid`.
    - On `mem_wnext`: if off = LINE_WORDS-1, go to FILL with off = 0; otherwise off+1 and go to WB_RD.
  - FILL: each `mem_rvalid` writes one word to port B at {idx, off}, then off+1.
    - On the last word, set valid = 1, dirty = 0 and tag = new tag, then go to IDLE.
- `mem_addr` gives the victim line {old tag, idx} in WB_RD/WB and the requested line in FILL.
- `mem_req` stays high across WB_RD/WB, drops for 1 cycle, then rises again for FILL.
- `cpu_ready` stays 0 in every non-IDLE state. After a fill, the retried access hits in the first IDLE cycle.
- Offset counter wraps at LINE_WORDS.

## Timing
- Reset values: state IDLE, all valid/dirty bits 0, off 0; `mem_req`, `mem_we`, `mem_wvalid`, `cpu_ready`, `flush_busy` all 0; `bram_a_wren`, `bram_b_wren` 0; `mem_addr`, `bram_b_addr` 0.
- Hit: `cpu_ready` is combinational in the same cycle as `cpu_req`. Read data appears on BRAM `q_a` 1 cycle later.
- Clean miss, request seen at cycle 0:
  - cycle 1: FILL, `mem_req` = 1.
  - last `mem_rvalid` at cycle N.
  - cycle N+1: IDLE with `cpu_ready` = 1.
- Writeback: at most one word per 2 cycles, because of the WB_RD read latency. `mem_wvalid` is 0 in WB_RD.
- `mem_rvalid` may assert on every cycle of FILL and is ignored outside FILL.
- Reset mid-burst: all state returns to reset values on the next edge. The memory side must abandon the burst when `mem_req` falls. The line being filled stays invalid.

## Configuration
- `BRAMCACHE_FLUSH_EN` defined:
  - `flush_req` sampled in IDLE, when no miss is pending, enters FLUSH_SCAN.
  - FLUSH_SCAN walks the line index 0 to 2**IDX_W-1. Each dirty line is written back through WB_RD/WB, which then return to FLUSH_SCAN. All lines are then invalidated, and the controller returns to IDLE.
  - `flush_busy` is 1 from the cycle after `flush_req` until IDLE is reached.
  - A `flush_req` that coincides with a miss is serviced after the miss.
- `BRAMCACHE_FLUSH_EN` undefined: `flush_req` is ignored, `flush_busy` is tied to 0, and the FLUSH_SCAN state is not built.

## Test plan
- After reset, read 0x00010: miss; `mem_req` = 1, `mem_we` = 0, `mem_addr` = 0x00002. Feed 8 words 0xA0..0xA7: `bram_b_wren` = 4'hF at addresses 0x10..0x17, then `cpu_ready` = 1 and `q_a` = 0xA0.
- Write hit 0x00011 with be = 4'b0011: `bram_a_wren` = 4'b0011 in the same cycle and dirty[2] = 1. A following read of 0x00011 hits with no `mem_req`.
- Read 0x00410, same index with a different tag, while line 2 is dirty: writeback with `mem_addr` = 0x00002 and 8 `mem_wvalid` words in order, including the modified word. Then a fill with `mem_addr` = 0x00082.
- Assert `reset` during the 4th fill word: next cycle `mem_req` = 0. A read of the same address misses again.
- Stall the memory side by holding `mem_wnext` low for 5 cycles mid-writeback: `mem_wvalid` and `mem_wdata` stay stable, and no word is skipped or duplicated.
- With `BRAMCACHE_FLUSH_EN`: dirty lines 1 and 6, pulse `flush_req` → exactly two writeback bursts in index order, then all valid bits 0 and `flush_busy` = 0.
